io_handshake_responder: RTL and testbench
=========================================

# io_handshake_responder

Peripheral-side end of the processor's user-I/O handshake. The control unit raises `is_input` or `is_output` and stalls until it sees `confirmation` or `continue_button`. This block holds that request and latches switch data or display data. It conditions the raw board buttons and returns exactly one single-cycle acknowledge per request. It sits between the board pins (switches, push-buttons, display) and the control/datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of datapath words
- `SWITCH_WIDTH`, 16, number of board switches, must be ≤ DATA_WIDTH
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles for a button level change; ≥ 2

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-low
- `is_input`  in  1  control requests user input; level, held until acknowledged
- `is_output`  in  1  control requests display output; level, held until acknowledged
- `cpu_data`  in  DATA_WIDTH  value to display, valid while `is_output` is high
- `switches`  in  SWITCH_WIDTH  raw asynchronous switch bank
- `confirm_raw`  in  1  raw confirm push-button, active-high
- `continue_raw`  in  1  raw continue push-button, active-high
- `input_data`  out  DATA_WIDTH  captured switches, zero-extended
- `display_data`  out  DATA_WIDTH  latched output value
- `confirmation`  out  1  one-cycle acknowledge of an input request
- `continue_button`  out  1  one-cycle acknowledge of an output request
- `waiting_user`  out  1  high in IN_WAIT or OUT_WAIT (LED)

## Operation
- **Button conditioning (per button):**
  - 2-flop synchronizer, then debounce.
  - The debounced level flips only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch break clears the counter.
  - A press event is the 0→1 transition of the debounced level. It lasts one cycle.
- **Switches:** 2-flop synchronized. No debounce.
- **FSM states:** IDLE, IN_WAIT, OUT_WAIT, ACK.
  - **IDLE**
    - `is_input` high → IN_WAIT. `is_input` has priority if both requests are high.
    - Else `is_output` high → OUT_WAIT, and `display_data` ← `cpu_data` on the same edge.
  - **IN_WAIT**
    - Confirm press event → `input_data` ← zero-extended synchronized switches. Pulse `confirmation` for one cycle, then → ACK.
    - `is_input` low before a press → IDLE (abort). No pulse, `input_data` unchanged.
  - **OUT_WAIT**
    - Continue press event → pulse `continue_button` for one cycle, then → ACK.
    - `is_output` low → IDLE (abort).
    - `display_data` is not re-latched while in OUT_WAIT.
  - **ACK**
    - Stay until `is_input` and `is_output` are both low, then → IDLE.
    - This guarantees one acknowledge per instruction even if control holds the request an extra cycle.
- **Discarded events:** press events in IDLE or ACK are dropped, never queued. Confirm events in OUT_WAIT and continue events in IN_WAIT are also dropped.
- **Hold:** `display_data` keeps its value until the next output request. `input_data` keeps its value until the next confirmed input.

## Timing
- **Reset (`reset`=0 at a rising edge):**
  - State IDLE.
  - `input_data`, `display_data` = 0.
  - `confirmation`, `continue_button`, `waiting_user` = 0.
  - Synchronizers, debounce counters and debounced levels = 0.
- **Reset mid-handshake:** abandon the request, no acknowledge pulse. A button held across reset release yields a press event after conditioning. Acknowledge it only if a request is pending by then.
- **Acknowledge latency:**
  - Raw button rises and stays stable.
  - Debounced level rises DEBOUNCE_CYCLES+2 edges later.
  - The acknowledge is registered on the next edge: total DEBOUNCE_CYCLES+3 edges.
  - The acknowledge is high for exactly one cycle.
- **Latches:** `display_data` is valid one edge after IDLE samples `is_output`. `input_data` updates on the same edge `confirmation` rises.
- **Request and press on the same edge:** a request arriving in IDLE on the same edge as a press event does not consume that event. The press must occur while in a WAIT state.
- `waiting_user` is registered, aligned with the state register.

## Structure
- **Package `io_pkg`:** FSM state encoding localparams (IO_IDLE, IO_IN_WAIT, IO_OUT_WAIT, IO_ACK) and a `clog2`-style function for the debounce counter width.
- **Sub-module `button_conditioner`:** synchronizer, debounce counter and rising-edge detector. Parameter DEBOUNCE_CYCLES; outputs `level` and `press`. Instantiate it twice.
- Top level holds the FSM, the switch synchronizer and the data latches.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- **Input path:**
  - Stimulus: switches=16'hA5C3, `is_input` high, confirm held 10 cycles.
  - Response: `confirmation` is a single pulse 7 edges after the press; `input_data`=32'h0000A5C3; state ACK until `is_input` drops, then IDLE.
- **Output path:**
  - Stimulus: `is_output` with `cpu_data`=32'hDEADBEEF; `cpu_data` changes to 0 afterwards; continue pressed.
  - Response: `display_data` stays 32'hDEADBEEF; one `continue_button` pulse.
- **Bounce rejection:**
  - Stimulus: confirm toggling every 2 cycles for 20 cycles during IN_WAIT.
  - Response: no pulse. A later stable press gives exactly one pulse.
- **Abort, simultaneous requests, stale presses:**
  - `is_input` dropped in IN_WAIT → IDLE, no pulse, `input_data` unchanged.
  - Both requests high in IDLE → IN_WAIT.
  - A press in IDLE → no pulse.
- **Held request:**
  - Stimulus: `is_input` kept high 5 cycles after `confirmation`, with a second press during that time.
  - Response: no second pulse.
- **Reset mid-handshake:**
  - Stimulus: `reset`=0 during OUT_WAIT.
  - Response: all outputs 0 next edge, state IDLE, no pulse afterwards without a new request.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the user-I/O handshake responder: FSM state encoding
// and a width helper for the button debounce counters.
package io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE     = 2'd0,
    IO_IN_WAIT  = 2'd1,
    IO_OUT_WAIT = 2'd2,
    IO_ACK      = 2'd3
  } io_state_t;

  // Bits needed to count 0 .. value-1; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw board push-button: 2-flop synchronizer, consecutive-cycle
// debounce and a one-cycle press pulse on the debounced rising edge.
module button_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  logic             level_q;
  logic [CNT_W-1:0] count;

  // NOTE: every flop here is sequential state, so all assignments are
  // non-blocking; blocking ones would collapse the synchronizer into one stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      count      <= '0;
    end else begin
      sync_meta  <= raw;
      sync_level <= sync_meta;
      level_q    <= level;
      if (sync_level == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= sync_level;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral side of the control unit's user-I/O handshake: holds the request,
// latches switch or display data and returns exactly one acknowledge per request.
module io_handshake_responder
  import io_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SWITCH_WIDTH    = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    is_input,
  input  logic                    is_output,
  input  logic [DATA_WIDTH-1:0]   cpu_data,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic                    confirm_raw,
  input  logic                    continue_raw,
  output logic [DATA_WIDTH-1:0]   input_data,
  output logic [DATA_WIDTH-1:0]   display_data,
  output logic                    confirmation,
  output logic                    continue_button,
  output logic                    waiting_user
);

  io_state_t               state;
  logic [SWITCH_WIDTH-1:0] switch_meta;
  logic [SWITCH_WIDTH-1:0] switch_sync;
  logic                    confirm_level;
  logic                    confirm_press;
  logic                    continue_level;
  logic                    continue_press;
  logic                    unused_levels;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clock (clock),
    .reset (reset),
    .raw   (confirm_raw),
    .level (confirm_level),
    .press (confirm_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue (
    .clock (clock),
    .reset (reset),
    .raw   (continue_raw),
    .level (continue_level),
    .press (continue_press)
  );

  // Debounced levels are only needed by integrators that drive button LEDs.
  assign unused_levels = confirm_level ^ continue_level;

  // Switches are slow levels; synchronizing is enough, no debounce.
  always_ff @(posedge clock) begin
    if (!reset) begin
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      switch_meta <= switches;
      switch_sync <= switch_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IO_IDLE;
      input_data      <= '0;
      display_data    <= '0;
      confirmation    <= 1'b0;
      continue_button <= 1'b0;
      waiting_user    <= 1'b0;
    end else begin
      confirmation    <= 1'b0;
      continue_button <= 1'b0;
      case (state)
        IO_IDLE: begin
          // Presses arriving here are dropped: only a WAIT state consumes them.
          if (is_input) begin
            state        <= IO_IN_WAIT;
            waiting_user <= 1'b1;
          end else if (is_output) begin
            state        <= IO_OUT_WAIT;
            display_data <= cpu_data;
            waiting_user <= 1'b1;
          end
        end
        IO_IN_WAIT: begin
          if (confirm_press) begin
            input_data   <= DATA_WIDTH'(switch_sync);
            confirmation <= 1'b1;
            state        <= IO_ACK;
            waiting_user <= 1'b0;
          end else if (!is_input) begin
            state        <= IO_IDLE;
            waiting_user <= 1'b0;
          end
        end
        IO_OUT_WAIT: begin
          if (continue_press) begin
            continue_button <= 1'b1;
            state           <= IO_ACK;
            waiting_user    <= 1'b0;
          end else if (!is_output) begin
            state        <= IO_IDLE;
            waiting_user <= 1'b0;
          end
        end
        IO_ACK: begin
          // Hold here until control drops its request so it is acked only once.
          if (!is_input && !is_output) state <= IO_IDLE;
        end
        default: begin
          state        <= IO_IDLE;
          waiting_user <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_handshake_responder.sv
// Self-checking bench for io_handshake_responder: directed protocol scenarios
// followed by randomized traffic, all compared against a history-based model.
module tb_io_handshake_responder;
  import io_pkg::*;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          is_input = 1'b0;
  logic          is_output = 1'b0;
  logic [DW-1:0] cpu_data = '0;
  logic [SW-1:0] switches = '0;
  logic          confirm_raw = 1'b0;
  logic          continue_raw = 1'b0;
  logic [DW-1:0] input_data;
  logic [DW-1:0] display_data;
  logic          confirmation;
  logic          continue_button;
  logic          waiting_user;

  int checks = 0;
  int errors = 0;
  int conf_seen = 0;
  int cont_seen = 0;

  always #5 clock = ~clock;

  io_handshake_responder #(
    .DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .is_input(is_input), .is_output(is_output),
    .cpu_data(cpu_data), .switches(switches), .confirm_raw(confirm_raw),
    .continue_raw(continue_raw), .input_data(input_data), .display_data(display_data),
    .confirmation(confirmation), .continue_button(continue_button),
    .waiting_user(waiting_user)
  );

  // Reference model: buttons are judged from a window of raw samples (the
  // debounced level flips once D consecutive samples, seen two edges late,
  // disagree with it); the handshake is tracked with pending/acked flags.
  bit            c_hist[$];
  bit            k_hist[$];
  logic [SW-1:0] s_hist[$];
  bit            m_lvl_c, m_lvl_k, m_press_c, m_press_k;
  bit            in_pending, out_pending, acked;
  logic [DW-1:0] exp_in, exp_disp;
  bit            exp_conf, exp_cont, exp_wait;

  function automatic bit window_disagrees(input bit hist[$], input bit lvl);
    for (int j = 2; j <= D + 1; j++) if (hist[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      c_hist.delete(); k_hist.delete(); s_hist.delete();
      for (int j = 0; j < D + 2; j++) begin
        c_hist.push_front(1'b0); k_hist.push_front(1'b0); s_hist.push_front('0);
      end
      m_lvl_c = 0; m_lvl_k = 0; m_press_c = 0; m_press_k = 0;
      in_pending = 0; out_pending = 0; acked = 0;
      exp_in = '0; exp_disp = '0; exp_conf = 0; exp_cont = 0; exp_wait = 0;
    end else begin
      bit new_c, new_k;
      c_hist.push_front(confirm_raw); k_hist.push_front(continue_raw);
      s_hist.push_front(switches);
      while (c_hist.size() > D + 2) begin
        void'(c_hist.pop_back()); void'(k_hist.pop_back()); void'(s_hist.pop_back());
      end
      exp_conf = 0;
      exp_cont = 0;
      if (acked) begin
        if (!is_input && !is_output) acked = 0;
      end else if (in_pending) begin
        if (m_press_c) begin
          exp_in = {{(DW - SW){1'b0}}, s_hist[2]};
          exp_conf = 1; in_pending = 0; acked = 1;
        end else if (!is_input) in_pending = 0;
      end else if (out_pending) begin
        if (m_press_k) begin
          exp_cont = 1; out_pending = 0; acked = 1;
        end else if (!is_output) out_pending = 0;
      end else if (is_input) begin
        in_pending = 1;
      end else if (is_output) begin
        out_pending = 1; exp_disp = cpu_data;
      end
      exp_wait = in_pending | out_pending;
      new_c = window_disagrees(c_hist, m_lvl_c) ? ~m_lvl_c : m_lvl_c;
      new_k = window_disagrees(k_hist, m_lvl_k) ? ~m_lvl_k : m_lvl_k;
      m_press_c = new_c & ~m_lvl_c;
      m_press_k = new_k & ~m_lvl_k;
      m_lvl_c = new_c;
      m_lvl_k = new_k;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n cycles; compare every output to the model on each falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("confirmation", confirmation, exp_conf);
      check("continue_button", continue_button, exp_cont);
      check("waiting_user", waiting_user, exp_wait);
      check("input_data", input_data, exp_in);
      check("display_data", display_data, exp_disp);
      if (confirmation) conf_seen++;
      if (continue_button) cont_seen++;
    end
  endtask

  task automatic wait_conf(input int limit, output int edges);
    edges = -1;
    for (int e = 1; e <= limit; e++) begin
      step(1);
      if (confirmation) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic release_buttons();
    confirm_raw = 0;
    continue_raw = 0;
    step(D + 4);
  endtask

  initial begin
    int edges;
    int base;
    logic [DW-1:0] saved;
    int c_left;
    int k_left;

    // Reset state
    @(negedge clock);
    step(3);
    check("reset_input_data", input_data, 32'h0);
    check("reset_display_data", display_data, 32'h0);
    check("reset_waiting", waiting_user, 1'b0);
    check("reset_state", dut.state, IO_IDLE);
    reset = 1;
    step(2);

    // Input path
    switches = 16'hA5C3;
    is_input = 1;
    step(2);
    check("in_wait_state", dut.state, IO_IN_WAIT);
    check("in_wait_led", waiting_user, 1'b1);
    base = conf_seen;
    confirm_raw = 1;
    wait_conf(20, edges);
    check("conf_latency", edges, D + 3);
    check("conf_input_data", input_data, 32'h0000A5C3);
    step(9);
    check("conf_single_pulse", conf_seen - base, 1);
    check("ack_state_held", dut.state, IO_ACK);
    check("ack_led_off", waiting_user, 1'b0);
    is_input = 0;
    step(1);
    check("ack_to_idle", dut.state, IO_IDLE);
    release_buttons();

    // Output path
    cpu_data = 32'hDEADBEEF;
    is_output = 1;
    step(1);
    cpu_data = 32'h0;
    step(2);
    check("display_latched", display_data, 32'hDEADBEEF);
    base = cont_seen;
    continue_raw = 1;
    step(12);
    check("cont_single_pulse", cont_seen - base, 1);
    check("display_held", display_data, 32'hDEADBEEF);
    is_output = 0;
    release_buttons();

    // Bounce rejection, then one clean press
    switches = 16'h1234;
    is_input = 1;
    step(2);
    base = conf_seen;
    for (int t = 0; t < 10; t++) begin
      confirm_raw = ~confirm_raw;
      step(2);
    end
    check("bounce_no_pulse", conf_seen - base, 0);
    confirm_raw = 1;
    step(12);
    check("clean_press_pulse", conf_seen - base, 1);
    check("clean_press_data", input_data, 32'h00001234);
    is_input = 0;
    release_buttons();

    // Abort of an input request
    saved = input_data;
    base = conf_seen;
    switches = 16'hFFFF;
    is_input = 1;
    step(3);
    is_input = 0;
    step(2);
    check("abort_idle", dut.state, IO_IDLE);
    check("abort_no_pulse", conf_seen - base, 0);
    check("abort_data_kept", input_data, saved);

    // Simultaneous requests: input wins, continue presses are dropped
    is_input = 1;
    is_output = 1;
    cpu_data = 32'h0BAD_F00D;
    step(2);
    check("both_in_wait", dut.state, IO_IN_WAIT);
    check("both_display_kept", display_data, 32'hDEADBEEF);
    base = cont_seen;
    continue_raw = 1;
    step(12);
    check("wrong_button_dropped", cont_seen - base, 0);
    is_input = 0;
    is_output = 0;
    release_buttons();

    // Stale press in IDLE is not queued
    base = conf_seen;
    confirm_raw = 1;
    step(10);
    is_input = 1;
    step(10);
    check("stale_press_dropped", conf_seen - base, 0);
    is_input = 0;
    release_buttons();

    // Request held past the acknowledge with a second press
    base = conf_seen;
    is_input = 1;
    confirm_raw = 1;
    wait_conf(20, edges);
    check("held_first_latency", edges, D + 3);
    confirm_raw = 0;
    step(D + 4);
    confirm_raw = 1;
    step(12);
    check("held_no_second_pulse", conf_seen - base, 1);
    check("held_still_ack", dut.state, IO_ACK);
    is_input = 0;
    release_buttons();

    // Reset in the middle of an output handshake
    cpu_data = 32'h0000_1234;
    is_output = 1;
    step(2);
    check("pre_reset_display", display_data, 32'h0000_1234);
    reset = 0;
    step(1);
    check("mid_reset_display", display_data, 32'h0);
    check("mid_reset_input", input_data, 32'h0);
    check("mid_reset_waiting", waiting_user, 1'b0);
    check("mid_reset_state", dut.state, IO_IDLE);
    reset = 1;
    is_output = 0;
    base = cont_seen;
    continue_raw = 1;
    step(12);
    check("post_reset_no_pulse", cont_seen - base, 0);
    release_buttons();

    // Randomized traffic against the model
    c_left = 0;
    k_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) is_input = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) is_output = 1'($urandom_range(0, 1));
      cpu_data = $urandom;
      switches = SW'($urandom);
      if (c_left == 0) begin
        confirm_raw = 1'($urandom_range(0, 1));
        c_left = $urandom_range(1, 14);
      end else c_left--;
      if (k_left == 0) begin
        continue_raw = 1'($urandom_range(0, 1));
        k_left = $urandom_range(1, 14);
      end else k_left--;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
